spi_bus_arbiter: RTL and testbench

Transaction-level arbiter that shares one SPI byte-transfer engine (the `spi_interface`-style block with `begin_transmission` / `end_transmission` / `send_data` / `recieved_data`) between two device controllers, e.g. the gyro controller and an accelerometer controller on a second chip select. It sits between the controllers and the engine. It grants the bus for a whole multi-byte transaction and drives the per-device chip selects. It forwards byte-start pulses and returns byte-done pulses and received data to the granted client. It enforces a programmable chip-select-high gap between transactions.

---
 rtl/spi_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_spi_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Two-client arbiter for a shared SPI byte engine.
// It grants the engine for a whole transaction and enforces a chip-select gap between transactions.
module spi_bus_arbiter #(
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       begin0,
    input  logic       begin1,
    input  logic [7:0] send0,
    input  logic [7:0] send1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       eng_begin,
    output logic [7:0] eng_send,
    input  logic       eng_end,
    input  logic [7:0] eng_rdata,
    output logic       eng_ss,
    output logic [1:0] cs_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] gap_cnt;
    logic       last;
    logic       inflight;
    logic       fire;
    logic       fin;
    logic       sel;

    assign sel = (state == GRANT1);

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, the client that was not served last wins.
                if (req0 && (!req1 || last))
                    state_nxt = GRANT0;
                else if (req1)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                fin  = inflight && eng_end;
                fire = !inflight && begin0;
                if (!req0 && !inflight && !begin0)
                    state_nxt = GAP;
            end
            GRANT1: begin
                fin  = inflight && eng_end;
                fire = !inflight && begin1;
                if (!req1 && !inflight && !begin1)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gap_cnt   <= 8'd0;
            last      <= 1'b1;
            inflight  <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            cs_n      <= 2'b11;
            eng_ss    <= 1'b1;
            eng_begin <= 1'b0;
            eng_send  <= 8'h00;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= 8'h00;
            rdata1    <= 8'h00;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
            if (state == IDLE && state_nxt != IDLE)
                last <= (state_nxt == GRANT1);
            gnt0      <= (state_nxt == GRANT0);
            gnt1      <= (state_nxt == GRANT1);
            cs_n      <= {state_nxt != GRANT1, state_nxt != GRANT0};
            eng_ss    <= !(state_nxt == GRANT0 || state_nxt == GRANT1);
            eng_begin <= fire;
            done0     <= fin && !sel;
            done1     <= fin && sel;
            if (fire) begin
                eng_send <= sel ? send1 : send0;
                inflight <= 1'b1;
            end
            if (fin) begin
                inflight <= 1'b0;
                if (sel)
                    rdata1 <= eng_rdata;
                else
                    rdata0 <= eng_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       gnt0;
    logic       gnt1;
    logic       begin0 = 1'b0;
    logic       begin1 = 1'b0;
    logic [7:0] send0 = 8'h00;
    logic [7:0] send1 = 8'h00;
    logic       done0;
    logic       done1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       eng_begin;
    logic [7:0] eng_send;
    logic       eng_end = 1'b0;
    logic [7:0] eng_rdata = 8'h00;
    logic       eng_ss;
    logic [1:0] cs_n;

    int pass_cnt = 0;
    int total = 0;

    spi_bus_arbiter #(.GAP_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1),
        .begin0(begin0), .begin1(begin1),
        .send0(send0), .send1(send1),
        .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .eng_begin(eng_begin), .eng_send(eng_send),
        .eng_end(eng_end), .eng_rdata(eng_rdata),
        .eng_ss(eng_ss), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for any grant; who = -1 when the bound expires.
    task automatic wait_grant(output int who, output int cycles, output logic cs_ok);
        who = -1;
        cycles = 0;
        cs_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cycles++;
            if (gnt0 || gnt1) begin
                who = gnt1 ? 1 : 0;
                break;
            end
            if (cs_n !== 2'b11 || eng_ss !== 1'b1)
                cs_ok = 1'b0;
        end
    endtask

    // One byte on the granted client: begin pulse, then engine completion.
    task automatic xfer(input int c, input logic [7:0] tx, input logic [7:0] rx,
                        output logic eb, output logic [7:0] es,
                        output logic dn, output logic [7:0] rd);
        if (c == 1) begin begin1 = 1'b1; send1 = tx; end
        else begin begin0 = 1'b1; send0 = tx; end
        tick();
        begin0 = 1'b0;
        begin1 = 1'b0;
        eb = eng_begin;
        es = eng_send;
        tick();
        eng_end = 1'b1;
        eng_rdata = rx;
        tick();
        eng_end = 1'b0;
        dn = (c == 1) ? done1 : done0;
        rd = (c == 1) ? rdata1 : rdata0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++; if ({gnt1, gnt0} !== 2'b00) $display("FAIL rst_gnt got %b want 00", {gnt1, gnt0}); else pass_cnt++;
        total++; if (cs_n !== 2'b11) $display("FAIL rst_cs_n got %b want 11", cs_n); else pass_cnt++;
        total++; if (eng_ss !== 1'b1) $display("FAIL rst_eng_ss got %b want 1", eng_ss); else pass_cnt++;
        total++; if ({eng_begin, done1, done0} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {eng_begin, done1, done0}); else pass_cnt++;
        total++; if ({eng_send, rdata1, rdata0} !== 24'h0) $display("FAIL rst_data got %h want 000000", {eng_send, rdata1, rdata0}); else pass_cnt++;
        rst = 1'b1;
        tick();
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        total++; if ({gnt1, gnt0} !== 2'b01) $display("FAIL first_grant got %b want 01", {gnt1, gnt0}); else pass_cnt++;
        total++; if (cs_n !== 2'b10 || eng_ss !== 1'b0) $display("FAIL first_cs got %b/%b want 10/0", cs_n, eng_ss); else pass_cnt++;
    endtask

    task automatic test_single_byte();
        logic eb, dn;
        logic [7:0] es, rd;
        begin0 = 1'b1;
        send0 = 8'hA5;
        tick();
        begin0 = 1'b0;
        total++; if (eng_begin !== 1'b1 || eng_send !== 8'hA5) $display("FAIL byte_begin got %b/%h want 1/a5", eng_begin, eng_send); else pass_cnt++;
        tick();
        total++; if (eng_begin !== 1'b0) $display("FAIL byte_begin_width got %b want 0", eng_begin); else pass_cnt++;
        eng_end = 1'b1;
        eng_rdata = 8'h3C;
        tick();
        eng_end = 1'b0;
        total++; if (done0 !== 1'b1 || done1 !== 1'b0) $display("FAIL byte_done got %b%b want 01", done1, done0); else pass_cnt++;
        total++; if (rdata0 !== 8'h3C || rdata1 !== 8'h00) $display("FAIL byte_rdata got %h/%h want 3c/00", rdata0, rdata1); else pass_cnt++;
        tick();
        total++; if (done0 !== 1'b0) $display("FAIL byte_done_width got %b want 0", done0); else pass_cnt++;
        eb = 1'b0; dn = 1'b0; es = 8'h00; rd = 8'h00;
    endtask

    task automatic test_round_robin();
        int who, cyc;
        logic cs_ok, eb, dn;
        logic [7:0] es, rd;
        req0 = 1'b0;
        wait_grant(who, cyc, cs_ok);
        req0 = 1'b1;
        total++; if (who !== 1) $display("FAIL rr_second got %0d want 1", who); else pass_cnt++;
        total++; if (cyc !== 10) $display("FAIL rr_gap_len got %0d want 10", cyc); else pass_cnt++;
        total++; if (cs_ok !== 1'b1) $display("FAIL rr_gap_cs got %b want 1", cs_ok); else pass_cnt++;
        xfer(1, 8'h5A, 8'hC3, eb, es, dn, rd);
        total++; if (eb !== 1'b1 || es !== 8'h5A) $display("FAIL rr_c1_begin got %b/%h want 1/5a", eb, es); else pass_cnt++;
        total++; if (dn !== 1'b1 || rd !== 8'hC3 || rdata0 !== 8'h3C) $display("FAIL rr_c1_done got %b/%h/%h want 1/c3/3c", dn, rd, rdata0); else pass_cnt++;
        req1 = 1'b0;
        tick();
        req1 = 1'b1;
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 0) $display("FAIL rr_third got %0d want 0", who); else pass_cnt++;
        xfer(0, 8'h11, 8'h3C, eb, es, dn, rd);
        total++; if (dn !== 1'b1 || rd !== 8'h3C) $display("FAIL rr_c0_done got %b/%h want 1/3c", dn, rd); else pass_cnt++;
        req0 = 1'b0;
        tick();
        req0 = 1'b1;
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 1) $display("FAIL rr_fourth got %0d want 1", who); else pass_cnt++;
        req1 = 1'b0;
        tick();
        req1 = 1'b1;
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 0) $display("FAIL rr_fifth got %0d want 0", who); else pass_cnt++;
    endtask

    task automatic test_late_release();
        int who, cyc;
        logic cs_ok;
        begin0 = 1'b1;
        send0 = 8'h44;
        tick();
        begin0 = 1'b0;
        req0 = 1'b0;
        tick();
        total++; if (gnt0 !== 1'b1) $display("FAIL late_hold1 got %b want 1", gnt0); else pass_cnt++;
        tick();
        total++; if (gnt0 !== 1'b1 || cs_n !== 2'b10) $display("FAIL late_hold2 got %b/%b want 1/10", gnt0, cs_n); else pass_cnt++;
        eng_end = 1'b1;
        eng_rdata = 8'h22;
        tick();
        eng_end = 1'b0;
        total++; if (done0 !== 1'b1 || gnt0 !== 1'b1 || rdata0 !== 8'h22) $display("FAIL late_done got %b/%b/%h want 1/1/22", done0, gnt0, rdata0); else pass_cnt++;
        tick();
        total++; if (gnt0 !== 1'b0 || cs_n !== 2'b11 || done0 !== 1'b0) $display("FAIL late_release got %b/%b/%b want 0/11/0", gnt0, cs_n, done0); else pass_cnt++;
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 1) $display("FAIL late_next got %0d want 1", who); else pass_cnt++;
    endtask

    task automatic test_isolation();
        logic seen;
        begin0 = 1'b1;
        send0 = 8'hFF;
        tick();
        begin0 = 1'b0;
        seen = eng_begin;
        tick();
        seen = seen | eng_begin;
        total++; if (seen !== 1'b0) $display("FAIL iso_begin got %b want 0", seen); else pass_cnt++;
        eng_end = 1'b1;
        eng_rdata = 8'h77;
        tick();
        eng_end = 1'b0;
        total++; if ({done1, done0} !== 2'b00) $display("FAIL iso_done got %b want 00", {done1, done0}); else pass_cnt++;
        total++; if (rdata1 !== 8'hC3 || rdata0 !== 8'h22) $display("FAIL iso_rdata got %h/%h want c3/22", rdata1, rdata0); else pass_cnt++;
    endtask

    task automatic test_begin_on_release();
        begin1 = 1'b1;
        send1 = 8'h6E;
        req1 = 1'b0;
        tick();
        begin1 = 1'b0;
        total++; if (eng_begin !== 1'b1 || eng_send !== 8'h6E || gnt1 !== 1'b1) $display("FAIL bor_begin got %b/%h/%b want 1/6e/1", eng_begin, eng_send, gnt1); else pass_cnt++;
        eng_end = 1'b1;
        eng_rdata = 8'h81;
        begin1 = 1'b1;
        tick();
        eng_end = 1'b0;
        begin1 = 1'b0;
        total++; if (done1 !== 1'b1 || rdata1 !== 8'h81 || eng_begin !== 1'b0) $display("FAIL bor_done got %b/%h/%b want 1/81/0", done1, rdata1, eng_begin); else pass_cnt++;
        tick();
        total++; if (gnt1 !== 1'b0 || eng_ss !== 1'b1) $display("FAIL bor_release got %b/%b want 0/1", gnt1, eng_ss); else pass_cnt++;
        repeat (12) tick();
    endtask

    task automatic test_mid_reset();
        int who, cyc;
        logic cs_ok;
        req0 = 1'b1;
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 0) $display("FAIL mr_grant got %0d want 0", who); else pass_cnt++;
        begin0 = 1'b1;
        send0 = 8'h99;
        tick();
        begin0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        total++; if ({gnt1, gnt0, cs_n, eng_ss} !== 5'b00111) $display("FAIL mr_ctrl got %b want 00111", {gnt1, gnt0, cs_n, eng_ss}); else pass_cnt++;
        total++; if ({eng_send, rdata1, rdata0} !== 24'h0) $display("FAIL mr_data got %h want 000000", {eng_send, rdata1, rdata0}); else pass_cnt++;
        rst = 1'b1;
        tick();
        wait_grant(who, cyc, cs_ok);
        total++; if (who !== 0) $display("FAIL mr_regrant got %0d want 0", who); else pass_cnt++;
        eng_end = 1'b1;
        eng_rdata = 8'hEE;
        tick();
        eng_end = 1'b0;
        total++; if ({done1, done0} !== 2'b00 || rdata0 !== 8'h00) $display("FAIL mr_stale got %b/%h want 00/00", {done1, done0}, rdata0); else pass_cnt++;
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_late_release();
        req0 = 1'b0;
        test_isolation();
        test_begin_on_release();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
